// File: rtl/aon_clk_div_pkg.sv
// Shared types and default parameter values for the AON clock divider controller.
package aon_clk_div_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        RUN     = 1'b1
    } state_t;

    localparam int CNT_W_DEFAULT        = 16;
    localparam int DEFAULT_HALF_DEFAULT = 255;

endpackage

// File: rtl/aon_clk_div_core.sv
// Half-period counter, terminal compare and output toggle for the AON divider.
// Also owns the in-effect terminal count so counter and compare value live together.
module aon_clk_div_core #(
    parameter int CNT_W        = 16,
    parameter int DEFAULT_HALF = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             load_half,
    input  logic [CNT_W-1:0] half,
    output logic             clk_out,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] cur_half
);

    logic [CNT_W-1:0] counter;
    logic             terminal;

    // rise/fall flag the edge on which clk_out is about to change
    assign terminal = run && (counter == cur_half);
    assign rise     = terminal && !clk_out;
    assign fall     = terminal && clk_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            counter  <= '0;
            clk_out  <= 1'b0;
            cur_half <= CNT_W'(DEFAULT_HALF);
        end else begin
            if (load_half) begin
                cur_half <= half;
            end
            if (!run) begin
                counter <= '0;
                clk_out <= 1'b0;
            end else if (terminal) begin
                counter <= '0;
                clk_out <= !clk_out;
            end else begin
                counter <= counter + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/aon_clk_div_ctrl.sv
// Run-time reconfigurable AON clock divider: config handshake, shadow registers and
// run/stop FSM; updates only land at a falling boundary so clk_out never glitches.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   STOPPED | clk_out parked low, counter cleared, cfg applied next edge
//   RUN     | dividing; queued cfg applied at the next falling boundary
module aon_clk_div_ctrl
    import aon_clk_div_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEFAULT,
    parameter int DEFAULT_HALF = DEFAULT_HALF_DEFAULT,
    parameter int RESET_RUN    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic             cfg_enable,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic [CNT_W-1:0] cur_half
);

    localparam state_t RESET_STATE = (RESET_RUN != 0) ? RUN : STOPPED;

    state_t           state;
    state_t           state_next;
    logic             pending;
    logic [CNT_W-1:0] shadow_half;
    logic             shadow_enable;
    logic             accept;
    logic             run;
    logic             rise;
    logic             fall;
    logic             load_half;
    logic [CNT_W-1:0] half_sel;

    assign run    = (state == RUN);
    assign accept = cfg_valid && cfg_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RESET_STATE;
            pending       <= 1'b0;
            shadow_half   <= CNT_W'(DEFAULT_HALF);
            shadow_enable <= 1'b1;
            tick          <= 1'b0;
        end else begin
            state <= state_next;
            tick  <= rise;
            // pending is never set while a fall applies it: cfg_ready is low then
            if (run && accept) begin
                pending       <= 1'b1;
                shadow_half   <= cfg_half;
                shadow_enable <= cfg_enable;
            end else if (fall && pending) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            STOPPED: if (accept && cfg_enable)               state_next = RUN;
            RUN:     if (fall && pending && !shadow_enable) state_next = STOPPED;
            default:                                         state_next = RESET_STATE;
        endcase
    end

    always_comb begin
        running   = run;
        cfg_ready = !pending;
        load_half = (!run && accept) || (fall && pending);
        half_sel  = run ? shadow_half : cfg_half;
    end

    aon_clk_div_core #(
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DEFAULT_HALF)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .load_half (load_half),
        .half      (half_sel),
        .clk_out   (clk_out),
        .rise      (rise),
        .fall      (fall),
        .cur_half  (cur_half)
    );

endmodule

// File: tb/tb_aon_clk_div_ctrl.sv
// Self-checking bench for aon_clk_div_ctrl against a phase-length reference model.
module tb_aon_clk_div_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [W-1:0] cfg_half = '0;
    logic         cfg_enable = 1'b1;
    logic         clk_out;
    logic         tick;
    logic         running;
    logic [W-1:0] cur_half;

    int n_vec = 0;
    int n_err = 0;

    aon_clk_div_ctrl #(.CNT_W(W), .DEFAULT_HALF(255), .RESET_RUN(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_half   (cfg_half),
        .cfg_enable (cfg_enable),
        .clk_out    (clk_out),
        .tick       (tick),
        .running    (running),
        .cur_half   (cur_half)
    );

    always #5 clk = !clk;

    // Reference model: each phase lasts half+1 cycles; at most one queued update,
    // which lands when a high phase ends.
    typedef struct packed {
        logic [W-1:0] half;
        logic         en;
    } cfg_t;

    cfg_t         pq[$];
    logic         m_level = 1'b0;
    logic         m_tick = 1'b0;
    logic         m_running = 1'b1;
    logic [W-1:0] m_half = 16'd255;
    int           m_left = 256;
    logic         m_acc = 1'b0;

    always @(posedge clk) begin
        bit acc;
        bit bnd;
        acc   = cfg_valid && (pq.size() == 0) && !reset;
        m_acc = acc;
        if (reset) begin
            m_running = 1'b1;
            m_level   = 1'b0;
            m_half    = 16'd255;
            m_left    = 256;
            m_tick    = 1'b0;
            pq.delete();
        end else if (!m_running) begin
            m_tick = 1'b0;
            if (acc) begin
                m_half = cfg_half;
                if (cfg_enable) begin
                    m_running = 1'b1;
                    m_left    = int'(m_half) + 1;
                end
            end
        end else begin
            bnd    = (m_left == 1);
            m_tick = bnd && !m_level;
            if (bnd) begin
                if (m_level && pq.size() > 0) begin
                    m_half = pq[0].half;
                    if (!pq[0].en) m_running = 1'b0;
                    pq.delete();
                end
                m_level = !m_level;
                m_left  = int'(m_half) + 1;
            end else begin
                m_left--;
            end
            if (acc) pq.push_back('{cfg_half, cfg_enable});
        end
    end

    function automatic logic [W+3:0] exp_vec();
        return {m_level, m_tick, m_running, (pq.size() == 0), m_half};
    endfunction

    function automatic logic [W+3:0] act_vec();
        return {clk_out, tick, running, cfg_ready, cur_half};
    endfunction

    task automatic drive_cfg(input logic [W-1:0] h, input logic en);
        cfg_valid  = 1'b1;
        cfg_half   = h;
        cfg_enable = en;
    endtask

    task automatic test_reset();
        int first_tick = -1;
        int second_tick = -1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 800; i++) begin
            @(negedge clk);
            n_vec++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL reset cyc %0d: outs(clk_out,tick,run,ready,half) got %h expected %h", i, act_vec(), exp_vec());
            end
            if (tick === 1'b1 && first_tick < 0) first_tick = i;
            else if (tick === 1'b1 && second_tick < 0) second_tick = i;
        end
        n_vec++;
        if (first_tick != 256) begin
            n_err++;
            $display("FAIL reset_first_rise: got cycle %0d expected 256", first_tick);
        end
        n_vec++;
        if (second_tick - first_tick != 512) begin
            n_err++;
            $display("FAIL reset_period: got %0d expected 512", second_tick - first_tick);
        end
    endtask

    task automatic test_change();
        int guard = 0;
        while (!(m_level && m_left > 10) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (guard >= 2000) begin
            n_err++;
            $display("FAIL change_wait_high: got timeout expected high phase");
        end
        drive_cfg(16'd3, 1'b1);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (m_acc) cfg_valid = 1'b0;
            n_vec++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL change cyc %0d: outs got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        n_vec++;
        if (cur_half !== 16'd3) begin
            n_err++;
            $display("FAIL change_half: got %0d expected 3", cur_half);
        end
    endtask

    task automatic test_stop();
        int guard = 0;
        while (!(!m_level && m_left > 2) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        drive_cfg(16'd3, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_acc) cfg_valid = 1'b0;
            n_vec++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL stop cyc %0d: outs got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        n_vec++;
        if (running !== 1'b0 || clk_out !== 1'b0) begin
            n_err++;
            $display("FAIL stop_final: got running=%b clk_out=%b expected 0/0", running, clk_out);
        end
    endtask

    task automatic test_div2();
        int ticks = 0;
        drive_cfg(16'd0, 1'b1);
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (m_acc) cfg_valid = 1'b0;
            if (tick === 1'b1) ticks++;
            n_vec++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL div2 cyc %0d: outs got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        n_vec++;
        if (ticks != 10) begin
            n_err++;
            $display("FAIL div2_ticks: got %0d expected 10", ticks);
        end
    endtask

    task automatic test_back_to_back();
        cfg_t todo[$];
        drive_cfg(16'd3, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_acc) cfg_valid = 1'b0;
        end
        for (int k = 0; k < 4; k++) todo.push_back('{16'($urandom_range(1, 6)), 1'b1});
        drive_cfg(todo[0].half, 1'b1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_acc) begin
                void'(todo.pop_front());
                if (todo.size() > 0) drive_cfg(todo[0].half, 1'b1);
                else cfg_valid = 1'b0;
            end
            n_vec++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL back_to_back cyc %0d: outs got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        n_vec++;
        if (todo.size() != 0) begin
            n_err++;
            $display("FAIL back_to_back_drain: got %0d left expected 0", todo.size());
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        int first_tick = -1;
        while (!(m_level && m_left > 1) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        drive_cfg(16'd7, 1'b1);
        @(negedge clk);
        cfg_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if (act_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_mid_clear: outs got %h expected %h", act_vec(), exp_vec());
        end
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (tick === 1'b1 && first_tick < 0) first_tick = i;
            n_vec++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL reset_mid cyc %0d: outs got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        n_vec++;
        if (first_tick != 256) begin
            n_err++;
            $display("FAIL reset_mid_first_rise: got cycle %0d expected 256", first_tick);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            n_vec++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc %0d: outs got %h expected %h", i, act_vec(), exp_vec());
            end
            reset = 1'b0;
            if (m_acc) cfg_valid = 1'b0;
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
            end else if (!cfg_valid && $urandom_range(0, 7) == 0) begin
                drive_cfg(16'($urandom_range(0, 9)), ($urandom_range(0, 4) != 0));
            end
        end
        reset     = 1'b0;
        cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_change();
        test_stop();
        test_div2();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
